// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Brief    : 8N1 UART transmitter with a one-byte holding register in front of
//            the shift register and a run-time selectable baud rate.
// Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baudrate_set,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [19:0] DIV_9600   = 20'(CLK_FREQ / 32'd9600);
  localparam logic [19:0] DIV_19200  = 20'(CLK_FREQ / 32'd19200);
  localparam logic [19:0] DIV_38400  = 20'(CLK_FREQ / 32'd38400);
  localparam logic [19:0] DIV_57600  = 20'(CLK_FREQ / 32'd57600);
  localparam logic [19:0] DIV_115200 = 20'(CLK_FREQ / 32'd115200);
  localparam logic [19:0] DIV_230400 = 20'(CLK_FREQ / 32'd230400);
  localparam logic [19:0] DIV_460800 = 20'(CLK_FREQ / 32'd460800);
  localparam logic [19:0] DIV_921600 = 20'(CLK_FREQ / 32'd921600);
  localparam logic [2:0]  LAST_STOP  = 3'(STOP_BITS - 1);

  state_t      state_q, state_d;
  logic [19:0] div_q, div_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_ready_q, tx_ready_d;
  logic        txd_q, txd_d;
  logic [19:0] div_sel;
  logic        take;

  always_comb begin
    case (baudrate_set)
      3'd0:    div_sel = DIV_9600;
      3'd1:    div_sel = DIV_19200;
      3'd2:    div_sel = DIV_38400;
      3'd3:    div_sel = DIV_57600;
      3'd4:    div_sel = DIV_115200;
      3'd5:    div_sel = DIV_230400;
      3'd6:    div_sel = DIV_460800;
      default: div_sel = DIV_921600;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    take        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) take = 1'b1;
      end
      START: begin
        if (cnt_q == 20'd0) begin
          state_d = DATA;
          cnt_d   = div_q - 20'd1;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      DATA: begin
        if (cnt_q == 20'd0) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = div_q - 20'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      STOP: begin
        // bit_q counts stop bits here; a waiting byte chains straight into START
        if (cnt_q == 20'd0) begin
          if (bit_q == LAST_STOP) begin
            if (hold_full_q) take = 1'b1;
            else             state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
            cnt_d = div_q - 20'd1;
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d     = START;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      div_d       = div_sel;
      cnt_d       = div_sel - 20'd1;
      bit_d       = 3'd0;
    end

    // A same-cycle refill overrides the emptying above
    if (tx_valid && tx_ready_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    tx_ready_d = ~hold_full_d;

    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= 20'd0;
      cnt_q       <= 20'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b1;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= tx_ready_d;
      txd_q       <= txd_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign txd      = txd_q;
  assign tx_busy  = (state_q != IDLE);

endmodule
`default_nettype wire
